// File: rtl/sync_down.sv
// sync_down: synchronous binary down counter built from per-bit JK stages, with terminal-count and wrap status.
// q and wrap change one clk after a non-reset edge (tc is combinational); no backpressure. Optional macro: SYNC_DOWN_LOAD_EN.

module sync_down_jk #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RST_BIT;
    end else begin
      unique case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module sync_down #(
  parameter int              WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SYNC_DOWN_LOAD_EN
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             count_en;

  // A down counter toggles bit i when every lower bit is zero (borrow ripples through).
  assign t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
    assign t[i] = &(~q[i-1:0]);
  end

`ifdef SYNC_DOWN_LOAD_EN
  assign count_en = en & ~load;

  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = d;
      k = ~d;
    end else if (en) begin
      j = t;
      k = t;
    end
  end
`else
  assign count_en = 1'b1;

  always_comb begin
    j = t;
    k = t;
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_down_jk #(
      .RST_BIT (RST_VAL[i])
    ) u_jk (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  assign tc = (q == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= count_en && (q == '0);
    end
  end

endmodule

// File: tb/tb_sync_down.sv
// Scoreboard bench for sync_down: a WIDTH=2/RST_VAL=0 instance and a WIDTH=4/RST_VAL=5 instance
// driven together, checked against an arithmetic model; load/enable cases are built with SYNC_DOWN_LOAD_EN.

module tb_sync_down;

  typedef struct {
    logic [15:0] q;
    logic        tc;
    logic        wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       load = 1'b0;
  logic [1:0] d2 = '0;
  logic [3:0] d4 = '0;

  logic [1:0] q2;
  logic       tc2, wrap2;
  logic [3:0] q4;
  logic       tc4, wrap4;

  exp_t sb2[$];
  exp_t sb4[$];

  int n_checks = 0;
  int n_pass = 0;
  int m2 = 0;
  int m4 = 0;

  always #5 clk = ~clk;

  sync_down #(.WIDTH(2), .RST_VAL(2'b00)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
`ifdef SYNC_DOWN_LOAD_EN
    .en   (en),
    .load (load),
    .d    (d2),
`endif
    .q    (q2),
    .tc   (tc2),
    .wrap (wrap2)
  );

  sync_down #(.WIDTH(4), .RST_VAL(4'h5)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
`ifdef SYNC_DOWN_LOAD_EN
    .en   (en),
    .load (load),
    .d    (d4),
`endif
    .q    (q4),
    .tc   (tc4),
    .wrap (wrap4)
  );

  // Model: next count from the priority rules using plain modular arithmetic.
  function automatic exp_t model(input int width, input int rst_val, inout int cnt,
                                 input logic r, input logic e, input logic ld, input int dv);
    exp_t x;
    int   modulus;
    modulus = 1 << width;
    x.wrap  = r && !ld && e && (cnt == 0);
    if (!r)      cnt = rst_val;
    else if (ld) cnt = dv;
    else if (e)  cnt = (cnt + modulus - 1) % modulus;
    x.q  = 16'(cnt);
    x.tc = (cnt == 0);
    return x;
  endfunction

  task automatic step(input logic r, input logic e, input logic ld, input logic [3:0] dv);
    @(negedge clk);
`ifndef SYNC_DOWN_LOAD_EN
    e  = 1'b1;
    ld = 1'b0;
`endif
    rst  = r;
    en   = e;
    load = ld;
    d2   = dv[1:0];
    d4   = dv;
    sb2.push_back(model(2, 0, m2, r, e, ld, int'(dv[1:0])));
    sb4.push_back(model(4, 5, m4, r, e, ld, int'(dv)));
  endtask

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act.q === exp.q && act.tc === exp.tc && act.wrap === exp.wrap) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t: got q=%h tc=%b wrap=%b, expected q=%h tc=%b wrap=%b",
               name, $time, act.q, act.tc, act.wrap, exp.q, exp.tc, exp.wrap);
    end
  endtask

  initial begin : monitor
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sb2.size() > 0) begin
        a.q = 16'(q2); a.tc = tc2; a.wrap = wrap2;
        compare("w2", a, sb2.pop_front());
      end
      if (sb4.size() > 0) begin
        a.q = 16'(q4); a.tc = tc4; a.wrap = wrap4;
        compare("w4", a, sb4.pop_front());
      end
    end
  end

  initial begin : driver
    // Reset, then a free run covering two full WIDTH=2 periods.
    step(1'b0, 1'b1, 1'b0, 4'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 4'h0);
    // Reset in the middle of a sequence, then resume.
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 4'h0);
`ifdef SYNC_DOWN_LOAD_EN
    step(1'b1, 1'b1, 1'b1, 4'hA);
    repeat (3) step(1'b1, 1'b0, 1'b0, 4'h3);
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'h3);
    step(1'b0, 1'b1, 1'b1, 4'hC);
    step(1'b1, 1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0);
`endif
    repeat (300) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
    end
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (sb2.size() == 0 && sb4.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", sb2.size(), sb4.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_down.md
Name: sync_down

Overview:
- Synchronous, free-running binary down counter, default 2 bits.
- Built from per-bit JK flip-flop stages with ripple-free synchronous toggle logic: every bit is clocked by the same clk.
- Used as a small sequencer/divider in the counters library.
- Provides the count plus terminal-count and wrap status.

Parameters:
- WIDTH, 2, counter width in bits (legal range 1..16).
- RST_VAL, 0, value loaded into q on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst  input  1  synchronous active-low reset; sampled only at posedge clk.
- q  output  WIDTH  current count; registered.
- tc  output  1  terminal count; combinational, 1 when q == 0.
- wrap  output  1  registered one-cycle pulse; 1 in the cycle after q went from 0 to all-ones.

Behaviour:
- Reset:
  - At posedge clk with rst == 0: q <= RST_VAL, wrap <= 0.
  - Reset has priority over counting and over all optional inputs.
  - Reset asserted mid-sequence takes effect at the next edge; no partial count.
- Counting: at each posedge clk with rst == 1, q <= q - 1 modulo 2^WIDTH.
- Wrap-around: q == 0 steps to all-ones (2'b11 for WIDTH=2); no stall, no saturation.
- Sequence from reset, WIDTH=2: 00 -> 11 -> 10 -> 01 -> 00 -> 11 ...; period is 2^WIDTH cycles.
- Latency: first decrement appears on the first posedge with rst == 1, i.e. the cycle after reset is released.
- Structure, required for this library:
  - Each bit i is a JK flip-flop instance with J = K = T_i.
  - T_0 = 1.
  - T_i = AND of ~q[j] for j < i.
  - JK stage rules: J=K=0 hold, J=1/K=0 set, J=0/K=1 clear, J=K=1 toggle.
  - The JK stage has its own synchronous active-low reset input, driven from rst, with a per-bit reset value taken from RST_VAL[i].
- tc:
  - Purely combinational from q; no glitch requirement beyond standard synchronous design.
  - Equals 1 during reset-held cycles if RST_VAL == 0.
- wrap:
  - wrap <= (rst == 1) && (q == 0) && counting enabled.
  - Asserted exactly one cycle per wrap event.
- No X propagation: after the first reset edge all outputs are known.
- Before the first reset edge, state is undefined; benches must reset first.

Optional Feature:
- Macro: SYNC_DOWN_LOAD_EN.
- When defined, three extra inputs are added after rst:
  - en (1 bit)
  - load (1 bit)
  - d (WIDTH bits)
- Priority at posedge, highest first:
  - rst == 0 -> RST_VAL.
  - else load == 1 -> q <= d, with wrap <= 0.
  - else en == 1 -> decrement as above.
  - else hold q, with wrap <= 0.
- JK stages are driven accordingly:
  - Load forces J = d[i], K = ~d[i].
  - Hold forces J = K = 0.
- When undefined: none of these ports exist and the counter decrements every non-reset cycle, so the port list is exactly clk, rst, q, tc, wrap.

Test Plan:
- Reset: hold rst=0 for 1 clk -> q=00, tc=1, wrap=0.
- Free run: release rst, run 8 clks -> q sequence 11,10,01,00,11,10,01,00; tc=1 only on q=00; wrap=1 in cycles where q=11 follows 00 (2 pulses).
- Reset mid-run: after 3 counts (q=01) drive rst=0 for 1 clk -> q=00 at that edge; counting resumes 11,10,... after release.
- Parameter check: WIDTH=4, RST_VAL=4'h5 -> after reset q=5, then 4,3,2,1,0,F,E; wrap pulses once after 0->F.
- With SYNC_DOWN_LOAD_EN:
  - load=1, d=10 -> q=10.
  - Then en=0 for 3 clks -> q stays 10.
  - Then en=1 -> 01, 00, 11.
  - load and rst=0 asserted together -> q=RST_VAL.
